dsp_text_seq: RTL and testbench
===============================

# dsp_text_seq

Text-mode display sequencer for the 640x480 character display. It divides the system clock into a pixel strobe and runs the horizontal and vertical counters. It fetches character and attribute bytes from screen RAM and glyph rows from the font ROM, then serializes the glyph bits. It drives the attribute, pixel, blank, sync and blink inputs of the downstream pixel colour stage, with sync and blank delayed to match the fetch pipeline.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP / H_SW / H_BP, 16 / 96 / 48, front porch, sync width, back porch (pixel ticks)
- V_VIS, 480, visible lines
- V_FP / V_SW / V_BP, 10 / 2 / 33, front porch, sync width, back porch (lines)
- COLS, 80, characters per row
- BLINK_BIT, 4, frame-counter bit used as blink phase
- clk  in  1  system clock (2x pixel rate)
- reset_n  in  1  asynchronous, active-low reset
- scr_addr  out  12  screen RAM word address, row*COLS+col
- scr_data  in  16  screen RAM read data: [15:8] attribute, [7:0] character; valid 1 clk after scr_addr
- font_addr  out  12  font ROM address {char[7:0], glyph_line[3:0]}
- font_data  in  8  glyph row, bit 7 = leftmost pixel; valid 1 clk after font_addr
- pixclk  out  1  pixel strobe, high every second clk
- attcode  out  8  attribute for current pixel
- pixel  out  1  glyph bit for current pixel (1 = foreground)
- blank  out  1  display enable: 1 = visible region, 0 = blanked
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blink  out  1  blink phase

## Operation
- pixclk toggles every clk. A "tick" is a clk edge where pixclk is 1. All counters advance only on ticks.
- h: 10 bits, 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SW+H_BP = 800. It wraps to 0, and v increments on the wrap.
- v: 10 bits, 0..V_TOTAL-1, where V_TOTAL = 525. It wraps to 0.
- Raw visible = (h<H_VIS)&(v<V_VIS).
- Raw hsync is low for H_VIS+H_FP <= h < H_VIS+H_FP+H_SW.
- Raw vsync is low for V_VIS+V_FP <= v < V_VIS+V_FP+V_SW.
- Fetch, per cell, when visible and h[2:0]==0:
  - Tick clk T: register scr_addr = (v>>4)*COLS + (h>>3). The multiply is done as (row<<6)+(row<<4) in 12 bits, with no overflow for 30x80.
  - T+1: latch attr_nx = scr_data[15:8] and register font_addr = {scr_data[7:0], v[3:0]}.
  - T+2: latch glyph_nx = font_data.
- Serialize: on the tick with h[2:0]==7, load shift <= glyph_nx and att_q <= attr_nx. If that cell was not visible, load 0 and 0x00 instead. On every other tick, shift <= shift<<1.
  - pixel = shift[7] and attcode = att_q, both registered. This gives 8 ticks of latency from counter position to pixel output.
- blank, hsync and vsync come from raw visible, hsync and vsync through an 8-stage shift register clocked on ticks, so they align exactly with pixel.
- Blink: a 5-bit frame counter increments on the tick where v wraps to 0. blink = frame_cnt[BLINK_BIT], which toggles every 16 frames.
- scr_addr and font_addr hold their value when no fetch is in progress.

## Timing
- Reset values (asynchronous):
  - pixclk=0; h=v=0; frame_cnt=0.
  - scr_addr=0, font_addr=0, shift=0, att_q=0, so pixel=0 and attcode=0x00.
  - blank=0, hsync=1, vsync=1, blink=0; delay-line stages hold 0/1/1.
- First clk edge after reset_n rises: pixclk=1 (first tick); h and v remain 0 on this tick.
- Memory latency is exactly 1 clk each. Font data is consumed at T+2, which is the next tick; there is no stall path.
- Output latency: counter position (h,v) appears on pixel, blank and syncs 8 ticks (16 clk) later.
- Wrap: h=799 → h=0 and v+1 on the same tick. h=799 with v=524 → h=0, v=0, and frame_cnt+1.
- Mid-frame reset: all state returns to reset values immediately, and the frame restarts at h=v=0.
- Only pixel, attcode, blank, hsync and vsync change on tick edges. blink changes on a tick edge. scr_addr changes only on fetch ticks, and font_addr only on T+1.

## Test plan
- Reset: assert reset_n=0 mid-line → all outputs at reset values within the same cycle. Release → pixclk pattern 1,0,1,0 and first pixel output after 8 ticks.
- Line/frame timing: run 2 frames → hsync low for exactly 96 ticks every 800 ticks, and vsync low for exactly 2 lines (1600 ticks) every 525 lines. blank=1 for 640 ticks per visible line and 0 for all of lines 480..524.
- Fetch addressing: at v=17, h=16 → scr_addr=82. Model returns 0x1E41 → font_addr=0x411 one clk later.
- Serialization: font model returns 0xA5 with attr 0x1E → pixel sequence 1,0,1,0,0,1,0,1 over 8 ticks, attcode=0x1E throughout, blank=1.
- Blink: count frames → blink rises after frame 16 and falls after frame 32, changing exactly at the v wrap.
- Blanked-cell load: at the first cell after the visible region → pixel=0 and attcode=0x00; scr_addr is unchanged during h>=640.

Source files
------------

// File: rtl/dsp_text_seq.sv
// Text-mode display sequencer: pixel strobe, raster counters, screen/font fetch,
// glyph serializer and sync/blank delay line for the downstream colour stage.
module dsp_text_seq #(
   parameter int H_VIS     = 640,
   parameter int H_FP      = 16,
   parameter int H_SW      = 96,
   parameter int H_BP      = 48,
   parameter int V_VIS     = 480,
   parameter int V_FP      = 10,
   parameter int V_SW      = 2,
   parameter int V_BP      = 33,
   parameter int BLINK_BIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [11:0] scr_addr,
   input  logic [15:0] scr_data,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        pixclk,
   output logic [7:0]  attcode,
   output logic        pixel,
   output logic        blank,
   output logic        hsync,
   output logic        vsync,
   output logic        blink
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

   logic [9:0]  h;
   logic [9:0]  v;
   logic [4:0]  frame_cnt;
   logic        tick;
   logic        h_end;
   logic        v_end;
   logic        vis_raw;
   logic        hs_raw;
   logic        vs_raw;
   logic        fetch;
   logic        fetch_d1;
   logic        fetch_d2;
   logic [5:0]  row;
   logic [11:0] cell_addr;
   logic [7:0]  attr_nx;
   logic [7:0]  glyph_nx;
   logic        cell_vis;
   logic [7:0]  shift;
   logic [7:0]  att_q;
   logic [7:0]  vis_dly;
   logic [7:0]  hs_dly;
   logic [7:0]  vs_dly;

   assign tick    = pixclk;
   assign h_end   = (h == 10'(H_TOTAL - 1));
   assign v_end   = (v == 10'(V_TOTAL - 1));
   assign vis_raw = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
   assign hs_raw  = !((h >= 10'(H_VIS + H_FP)) && (h < 10'(H_VIS + H_FP + H_SW)));
   assign vs_raw  = !((v >= 10'(V_VIS + V_FP)) && (v < 10'(V_VIS + V_FP + V_SW)));
   assign fetch   = tick && vis_raw && (h[2:0] == 3'd0);

   // row*80 as two shifts; 29*80+79 still fits in 12 bits
   assign row       = v[9:4];
   assign cell_addr = {row, 6'b0} + {2'b0, row, 4'b0} + {5'b0, h[9:3]};

   assign pixel   = shift[7];
   assign attcode = att_q;
   assign blank   = vis_dly[7];
   assign hsync   = hs_dly[7];
   assign vsync   = vs_dly[7];
   assign blink   = frame_cnt[BLINK_BIT];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixclk <= 1'b0;
      end else begin
         pixclk <= ~pixclk;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h         <= 10'd0;
         v         <= 10'd0;
         frame_cnt <= 5'd0;
      end else if (tick) begin
         if (h_end) begin
            h <= 10'd0;
            if (v_end) begin
               v         <= 10'd0;
               frame_cnt <= frame_cnt + 5'd1;
            end else begin
               v <= v + 10'd1;
            end
         end else begin
            h <= h + 10'd1;
         end
      end
   end

   // v cannot change between T and T+1 because fetches never start at h_end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scr_addr  <= 12'd0;
         font_addr <= 12'd0;
         attr_nx   <= 8'd0;
         glyph_nx  <= 8'd0;
         fetch_d1  <= 1'b0;
         fetch_d2  <= 1'b0;
      end else begin
         fetch_d1 <= fetch;
         fetch_d2 <= fetch_d1;
         if (fetch) begin
            scr_addr <= cell_addr;
         end
         if (fetch_d1) begin
            attr_nx   <= scr_data[15:8];
            font_addr <= {scr_data[7:0], v[3:0]};
         end
         if (fetch_d2) begin
            glyph_nx <= font_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cell_vis <= 1'b0;
         shift    <= 8'd0;
         att_q    <= 8'd0;
      end else if (tick) begin
         if (h[2:0] == 3'd0) begin
            cell_vis <= vis_raw;
         end
         if (h[2:0] == 3'd7) begin
            shift <= cell_vis ? glyph_nx : 8'd0;
            att_q <= cell_vis ? attr_nx : 8'd0;
         end else begin
            shift <= {shift[6:0], 1'b0};
         end
      end
   end

   // Eight tick stages line the raster flags up with the serializer output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vis_dly <= 8'h00;
         hs_dly  <= 8'hFF;
         vs_dly  <= 8'hFF;
      end else if (tick) begin
         vis_dly <= {vis_dly[6:0], vis_raw};
         hs_dly  <= {hs_dly[6:0], hs_raw};
         vs_dly  <= {vs_dly[6:0], vs_raw};
      end
   end

endmodule

// File: tb/tb_dsp_text_seq.sv
// Bench for dsp_text_seq on a shrunken raster: directed checks plus a
// position-based reference of what each output should show every clk.
module tb_dsp_text_seq;

   localparam int HV    = 32;
   localparam int HF    = 8;
   localparam int HS    = 8;
   localparam int HB    = 8;
   localparam int HT    = HV + HF + HS + HB;
   localparam int VV    = 20;
   localparam int VF    = 2;
   localparam int VS    = 2;
   localparam int VB    = 2;
   localparam int VT    = VV + VF + VS + VB;
   localparam int BB    = 2;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] scr_addr;
   logic [15:0] scr_data;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic        pixclk;
   logic [7:0]  attcode;
   logic        pixel;
   logic        blank;
   logic        hsync;
   logic        vsync;
   logic        blink;

   int          checks = 0;
   int          errors = 0;
   int          k;
   logic [11:0] exp_scr;
   logic [11:0] exp_font;
   logic        fetch_pend;
   logic [3:0]  fetch_line;
   int          hs_cnt;
   int          vs_cnt;
   int          blank_cnt;
   logic        e_pix;
   logic        e_blank;
   logic        e_hs;
   logic        e_vs;
   logic        e_blink;
   logic [7:0]  e_att;

   always #5 clk = ~clk;

   function automatic logic [15:0] scr_model(input logic [11:0] a);
      if (a == 12'd82) return 16'h1E41;
      return {a[7:0] ^ 8'h3C, a[7:0] + 8'h21};
   endfunction

   function automatic logic [7:0] font_model(input logic [11:0] a);
      if (a == 12'h411) return 8'hA5;
      return a[11:4] ^ {a[3:0], a[3:0]} ^ 8'h96;
   endfunction

   function automatic logic [11:0] cell_of(input int hh, input int vv);
      return 12'((vv / 16) * 80 + hh / 8);
   endfunction

   assign scr_data  = scr_model(scr_addr);
   assign font_data = font_model(font_addr);

   dsp_text_seq #(
      .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB),
      .BLINK_BIT(BB)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .scr_addr(scr_addr),
      .scr_data(scr_data),
      .font_addr(font_addr),
      .font_data(font_data),
      .pixclk(pixclk),
      .attcode(attcode),
      .pixel(pixel),
      .blank(blank),
      .hsync(hsync),
      .vsync(vsync),
      .blink(blink)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h (tick %0d)", tag, got, exp, k);
      end
   endtask

   // Expected outputs after tick kk: they show the raster position of tick kk-7
   task automatic computeExpected(input int kk);
      int p, oh, ov;
      logic [15:0] d;
      logic [7:0]  g;
      e_blink = 1'((((kk + 1) / FRAME) >> BB) & 1);
      e_pix = 1'b0;
      e_att = 8'h00;
      if (kk < 7) begin
         e_blank = 1'b0;
         e_hs    = 1'b1;
         e_vs    = 1'b1;
      end else begin
         p  = kk - 7;
         oh = p % HT;
         ov = (p / HT) % VT;
         e_blank = (oh < HV) && (ov < VV);
         e_hs    = !((oh >= HV + HF) && (oh < HV + HF + HS));
         e_vs    = !((ov >= VV + VF) && (ov < VV + VF + VS));
         if (e_blank) begin
            d = scr_model(cell_of(oh, ov));
            g = font_model({d[7:0], 4'(ov % 16)});
            e_pix = g[7 - (oh % 8)];
            e_att = d[15:8];
         end
      end
   endtask

   task automatic checkAll(input string phase);
      checkOutput({phase, "_pixel"}, pixel, e_pix);
      checkOutput({phase, "_attcode"}, attcode, e_att);
      checkOutput({phase, "_blank"}, blank, e_blank);
      checkOutput({phase, "_hsync"}, hsync, e_hs);
      checkOutput({phase, "_vsync"}, vsync, e_vs);
      checkOutput({phase, "_blink"}, blink, e_blink);
      checkOutput({phase, "_scr_addr"}, scr_addr, exp_scr);
      checkOutput({phase, "_font_addr"}, font_addr, exp_font);
   endtask

   task automatic checkReset(input string phase, input logic exp_pixclk);
      checkOutput({phase, "_pixclk"}, pixclk, exp_pixclk);
      checkOutput({phase, "_scr_addr"}, scr_addr, 12'd0);
      checkOutput({phase, "_font_addr"}, font_addr, 12'd0);
      checkOutput({phase, "_pixel"}, pixel, 1'b0);
      checkOutput({phase, "_attcode"}, attcode, 8'h00);
      checkOutput({phase, "_blank"}, blank, 1'b0);
      checkOutput({phase, "_hsync"}, hsync, 1'b1);
      checkOutput({phase, "_vsync"}, vsync, 1'b1);
      checkOutput({phase, "_blink"}, blink, 1'b0);
   endtask

   // Release at a falling edge so the next rising edge is the non-tick first edge
   task automatic releaseReset;
      @(negedge clk);
      reset_n    = 1'b1;
      k          = 0;
      exp_scr    = 12'd0;
      exp_font   = 12'd0;
      fetch_pend = 1'b0;
      fetch_line = 4'd0;
      hs_cnt     = 0;
      vs_cnt     = 0;
      blank_cnt  = 0;
      @(negedge clk);
      checkReset("first_edge", 1'b1);
   endtask

   task automatic applyStimulus(input int nticks);
      int hk, vk, p, oh, ov;
      logic [15:0] d;
      logic [7:0]  ref_glyph;
      ref_glyph = 8'hA5;
      for (int i = 0; i < nticks; i++) begin
         hk = k % HT;
         vk = (k / HT) % VT;
         @(negedge clk);
         if ((hk < HV) && (vk < VV) && (hk % 8 == 0)) begin
            exp_scr    = cell_of(hk, vk);
            fetch_pend = 1'b1;
            fetch_line = 4'(vk % 16);
         end
         computeExpected(k);
         checkOutput("tick_pixclk", pixclk, 1'b0);
         checkAll("tick");
         if (hk == 16 && vk == 17) checkOutput("scr_addr_82", scr_addr, 12'd82);
         if (k >= 7) begin
            p  = k - 7;
            oh = p % HT;
            ov = (p / HT) % VT;
            if (ov == 17 && oh >= 16 && oh < 24) begin
               checkOutput("ser_a5_pixel", pixel, ref_glyph[23 - oh]);
               checkOutput("ser_a5_attcode", attcode, 8'h1E);
               checkOutput("ser_a5_blank", blank, 1'b1);
            end
            hs_cnt    += (hsync == 1'b0) ? 1 : 0;
            vs_cnt    += (vsync == 1'b0) ? 1 : 0;
            blank_cnt += (blank == 1'b1) ? 1 : 0;
            if (oh == HT - 1) begin
               checkOutput("hsync_width", hs_cnt, HS);
               checkOutput("blank_per_line", blank_cnt, (ov < VV) ? HV : 0);
               hs_cnt    = 0;
               blank_cnt = 0;
               if (ov == VT - 1) begin
                  checkOutput("vsync_width", vs_cnt, VS * HT);
                  vs_cnt = 0;
               end
            end
         end
         if ((k + 1) % FRAME == 0) checkOutput("blink_at_wrap", blink, e_blink);
         @(negedge clk);
         if (fetch_pend) begin
            d          = scr_model(exp_scr);
            exp_font   = {d[7:0], fetch_line};
            fetch_pend = 1'b0;
            if (hk == 16 && vk == 17) checkOutput("font_addr_411", font_addr, 12'h411);
         end
         checkOutput("half_pixclk", pixclk, 1'b1);
         checkAll("half");
         k++;
      end
   endtask

   initial begin
      $display("[TB] dsp_text_seq bench start");
      k = 0;
      #12;
      checkReset("por", 1'b0);
      releaseReset();
      applyStimulus(300);
      #2 reset_n = 1'b0;
      #1 checkReset("mid_reset", 1'b0);
      repeat (2) @(negedge clk);
      checkReset("reset_hold", 1'b0);
      releaseReset();
      applyStimulus(8 * FRAME + 60);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
